// File: rtl/risc16_mem_arb_if.sv
// Bus bundle between the RISC-16 requesters, the memory arbiter and its RAM.
// Latency: none here; this is wiring only.
// Backpressure: a requester holds its request until the matching ack is seen.
interface risc16_mem_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  // Instruction-fetch port (read-only)
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  // MEM-stage data port (read/write)
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic              dm_rvalid_o;
  logic [DATA_W-1:0] dm_rdata_o;

  // Synchronous single-port RAM
  logic              ram_re_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  // Arbiter view
  modport slave (
    input  if_req_i, if_addr_i,
    output if_ack_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_ack_o, dm_rvalid_o, dm_rdata_o,
    output ram_re_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  // Requester / RAM view
  modport master (
    output if_req_i, if_addr_i,
    input  if_ack_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_ack_o, dm_rvalid_o, dm_rdata_o,
    input  ram_re_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/risc16_mem_arb.sv
// Shares one synchronous single-port RAM between instruction fetch and the MEM-stage data port.
// Latency: ack in the request cycle, RAM command +1, read data on rdata/rvalid +3; one access per cycle.
// Backpressure: an un-acked requester holds its request; data wins unless fetch has sat through STARVE_LIMIT data grants.
module risc16_mem_arb #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  risc16_mem_arb_if.slave bus
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic             PORT_IF = 1'b0;
  localparam logic             PORT_DM = 1'b1;

  // Arbitration state
  logic [CNT_W-1:0]  r_starve_cnt;

  // Registered RAM command
  logic              r_ram_re;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  // Response pipeline: stage 1 rides with the command, stage 2 with ram_rdata_i
  logic              r_s1_vld;
  logic              r_s1_port;
  logic              r_s2_vld;
  logic              r_s2_port;

  // Registered responses
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_dm_rdata;

  // Combinational grant signals
  logic              w_dm_wins;
  logic              w_grant_dm;
  logic              w_grant_if;
  logic              w_dm_write;
  logic              w_issue_rd;
  logic [ADDR_W-1:0] w_addr;

  // Grant: data has priority until fetch has waited LIMIT consecutive data grants.
  // Acks are forced low while reset is held so nothing is accepted into a dead pipeline.
  always_comb begin
    w_dm_wins  = bus.dm_req_i && (!bus.if_req_i || (r_starve_cnt < LIMIT));
    w_grant_dm = w_dm_wins && !rst_i;
    w_grant_if = bus.if_req_i && !w_dm_wins && !rst_i;
    w_dm_write = w_grant_dm && bus.dm_we_i;
    w_issue_rd = w_grant_if || (w_grant_dm && !bus.dm_we_i);
    w_addr     = w_grant_dm ? bus.dm_addr_i : bus.if_addr_i;
  end

  assign bus.if_ack_o = w_grant_if;
  assign bus.dm_ack_o = w_grant_dm;

  // Starvation counter: counts data grants fetch sat through; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_dm && bus.if_req_i) begin
      if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // RAM command register: strobes follow the grant; address/data hold when idle to avoid toggling.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_re <= w_issue_rd;
      r_ram_we <= w_dm_write;
      if (w_grant_dm || w_grant_if) begin
        r_ram_addr <= w_addr;
      end
      if (w_dm_write) begin
        r_ram_wdata <= bus.dm_wdata_i;
      end
    end
  end

  // Response pipeline: only reads enter it, tagged with the owning port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_vld  <= 1'b0;
      r_s1_port <= PORT_IF;
      r_s2_vld  <= 1'b0;
      r_s2_port <= PORT_IF;
    end else begin
      r_s1_vld  <= w_issue_rd;
      r_s1_port <= w_grant_dm ? PORT_DM : PORT_IF;
      r_s2_vld  <= r_s1_vld;
      r_s2_port <= r_s1_port;
    end
  end

  // Response routing: RAM data lands in the owner's holding register with a one-cycle rvalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= r_s2_vld && (r_s2_port == PORT_IF);
      r_dm_rvalid <= r_s2_vld && (r_s2_port == PORT_DM);
      if (r_s2_vld && (r_s2_port == PORT_IF)) begin
        r_if_rdata <= bus.ram_rdata_i;
      end
      if (r_s2_vld && (r_s2_port == PORT_DM)) begin
        r_dm_rdata <= bus.ram_rdata_i;
      end
    end
  end

  assign bus.ram_re_o    = r_ram_re;
  assign bus.ram_we_o    = r_ram_we;
  assign bus.ram_addr_o  = r_ram_addr;
  assign bus.ram_wdata_o = r_ram_wdata;

  assign bus.if_rvalid_o = r_if_rvalid;
  assign bus.if_rdata_o  = r_if_rdata;
  assign bus.dm_rvalid_o = r_dm_rvalid;
  assign bus.dm_rdata_o  = r_dm_rdata;

  // The two acks can never be high together.
  a_ack_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.if_ack_o && bus.dm_ack_o));

  // A RAM cycle never reads and writes at once.
  a_strobe_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.ram_re_o && bus.ram_we_o));

endmodule

// File: tb/tb_risc16_mem_arb.sv
`timescale 1ns/1ps
module tb_risc16_mem_arb;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LIM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  risc16_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  risc16_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Power-on contents of the RAM, shared by the RAM model and the reference model
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h10) return 16'hBEEF;
    if (a < 8)     return 16'(32'h100 + a);
    return 16'(32'hA000 ^ a);
  endfunction

  // Synchronous single-port RAM seen by the DUT
  logic [DW-1:0] ram_mem [256];
  bit            ram_wr  [256];
  always @(posedge clk) begin
    if (bus.ram_we_o) begin
      ram_mem[bus.ram_addr_o] <= bus.ram_wdata_o;
      ram_wr[bus.ram_addr_o]  <= 1'b1;
    end
    if (bus.ram_re_o)
      bus.ram_rdata_i <= ram_wr[bus.ram_addr_o] ? ram_mem[bus.ram_addr_o]
                                                : init_val(int'(bus.ram_addr_o));
  end

  // ---------------- reference model ----------------
  // Timeline of what must appear on the outputs, keyed by absolute cycle number.
  typedef struct packed {
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
  typedef struct packed {
    logic          iv;
    logic          dv;
    logic [DW-1:0] data;
  } rsp_t;

  cmd_t          exp_cmd [int];
  rsp_t          exp_rsp [int];
  logic [DW-1:0] mm      [256];
  bit            mm_wr   [256];
  int            fetch_waited = 0;   // data grants in a row while fetch was asking
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_dm_rdata = '0;

  function automatic logic [DW-1:0] mm_rd(input logic [AW-1:0] a);
    return mm_wr[a] ? mm[a] : init_val(int'(a));
  endfunction

  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    bit   g_i, g_d;
    if (rst) begin
      chk("rst if_ack",      bus.if_ack_o,    0);
      chk("rst dm_ack",      bus.dm_ack_o,    0);
      chk("rst if_rvalid",   bus.if_rvalid_o, 0);
      chk("rst dm_rvalid",   bus.dm_rvalid_o, 0);
      chk("rst if_rdata",    bus.if_rdata_o,  0);
      chk("rst dm_rdata",    bus.dm_rdata_o,  0);
      chk("rst ram_re",      bus.ram_re_o,    0);
      chk("rst ram_we",      bus.ram_we_o,    0);
      chk("rst ram_addr",    bus.ram_addr_o,  0);
      chk("rst ram_wdata",   bus.ram_wdata_o, 0);
      exp_cmd.delete();
      exp_rsp.delete();
      fetch_waited = 0;
      m_if_rdata   = '0;
      m_dm_rdata   = '0;
    end else begin
      c = exp_cmd.exists(cyc) ? exp_cmd[cyc] : '0;
      r = exp_rsp.exists(cyc) ? exp_rsp[cyc] : '0;
      exp_cmd.delete(cyc);
      exp_rsp.delete(cyc);

      chk("ram_re", bus.ram_re_o, c.re);
      chk("ram_we", bus.ram_we_o, c.we);
      if (c.re || c.we) chk("ram_addr",  bus.ram_addr_o,  c.addr);
      if (c.we)         chk("ram_wdata", bus.ram_wdata_o, c.wdata);

      chk("if_rvalid", bus.if_rvalid_o, r.iv);
      chk("dm_rvalid", bus.dm_rvalid_o, r.dv);
      if (r.iv) m_if_rdata = r.data;
      if (r.dv) m_dm_rdata = r.data;
      chk("if_rdata", bus.if_rdata_o, m_if_rdata);
      chk("dm_rdata", bus.dm_rdata_o, m_dm_rdata);

      // Data wins unless fetch has already waited out LIM data grants
      g_d = bus.dm_req_i && !(bus.if_req_i && fetch_waited >= LIM);
      g_i = bus.if_req_i && !g_d;
      chk("if_ack", bus.if_ack_o, g_i);
      chk("dm_ack", bus.dm_ack_o, g_d);

      if (g_d && bus.if_req_i) fetch_waited = (fetch_waited >= LIM) ? LIM : fetch_waited + 1;
      else                     fetch_waited = 0;

      if (g_i) begin
        c = '0; c.re = 1'b1; c.addr = bus.if_addr_i;
        exp_cmd[cyc + 1] = c;
        r = '0; r.iv = 1'b1; r.data = mm_rd(bus.if_addr_i);
        exp_rsp[cyc + 3] = r;
      end else if (g_d && bus.dm_we_i) begin
        c = '0; c.we = 1'b1; c.addr = bus.dm_addr_i; c.wdata = bus.dm_wdata_i;
        exp_cmd[cyc + 1] = c;
        mm[bus.dm_addr_i]    = bus.dm_wdata_i;
        mm_wr[bus.dm_addr_i] = 1'b1;
      end else if (g_d) begin
        c = '0; c.re = 1'b1; c.addr = bus.dm_addr_i;
        exp_cmd[cyc + 1] = c;
        r = '0; r.dv = 1'b1; r.data = mm_rd(bus.dm_addr_i);
        exp_rsp[cyc + 3] = r;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Inputs change 1 ns after the rising edge; direct checks sample 4 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]    pattern;
  logic [3:0]    pat4;
  logic [AW-1:0] fa, da;
  bit            ai, ad;
  int            pulses, if_pulses, dm_pulses, acks;

  initial begin
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = '0;
    bus.dm_wdata_i = '0;
    rst            = 1'b1;
    tick();
    tick();

    // Reset held: a request is not acknowledged
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 8'h10;
    #3 chk("no ack during reset", bus.if_ack_o, 0);

    // Single fetch of 0x10, starting in the first cycle after reset release
    tick(); rst = 1'b0;
    #3 chk("fetch ack c0", bus.if_ack_o, 1);
    tick(); bus.if_req_i = 1'b0;
    #3 chk("fetch ram_re c1", bus.ram_re_o, 1);
       chk("fetch ram_addr c1", bus.ram_addr_o, 8'h10);
    tick();
    #3 chk("fetch rvalid c2", bus.if_rvalid_o, 0);
    tick();
    #3 chk("fetch rvalid c3", bus.if_rvalid_o, 1);
       chk("fetch rdata c3", bus.if_rdata_o, 16'hBEEF);
       chk("fetch dm_rvalid c3", bus.dm_rvalid_o, 0);
    tick();
    #3 chk("fetch rvalid c4", bus.if_rvalid_o, 0);
       chk("fetch rdata held", bus.if_rdata_o, 16'hBEEF);

    // Data write 0x1234 to 0x20, then read it back
    tick();
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 8'h20; bus.dm_wdata_i = 16'h1234;
    #3 chk("wr ack c0", bus.dm_ack_o, 1);
    tick(); bus.dm_we_i = 1'b0;
    #3 chk("wr ram_we c1", bus.ram_we_o, 1);
       chk("wr ram_wdata c1", bus.ram_wdata_o, 16'h1234);
       chk("rd ack c1", bus.dm_ack_o, 1);
    pulses = 0;
    tick(); bus.dm_req_i = 1'b0;
    #3 chk("rd ram_re c2", bus.ram_re_o, 1);
       chk("rd ram_we c2", bus.ram_we_o, 0);
    for (int k = 3; k <= 6; k++) begin
      tick();
      #3 if (bus.dm_rvalid_o) pulses++;
      if (k == 4) begin
        chk("rd dm_rvalid c4", bus.dm_rvalid_o, 1);
        chk("rd dm_rdata c4", bus.dm_rdata_o, 16'h1234);
      end
    end
    chk("rd rvalid pulse count", pulses, 1);

    // Contention: both ports request continuously
    tick();
    fa = 8'h40; da = 8'h80; pattern = '0; if_pulses = 0; dm_pulses = 0;
    bus.if_req_i = 1'b1; bus.if_addr_i = fa;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = da;
    for (int k = 0; k < 12; k++) begin
      #3;
      if (k < 8) pattern = {pattern[6:0], bus.dm_ack_o};
      if (bus.if_rvalid_o) if_pulses++;
      if (bus.dm_rvalid_o) dm_pulses++;
      ai = bus.if_ack_o; ad = bus.dm_ack_o;
      tick();
      if (ai) fa = fa + 1'b1;
      if (ad) da = da + 1'b1;
      bus.if_addr_i = fa;
      bus.dm_addr_i = da;
      if (k >= 7) begin bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0; end
    end
    chk("contention grants DDDIDDDI", pattern, 8'b1110_1110);
    chk("contention fetch responses", if_pulses, 2);
    chk("contention data responses", dm_pulses, 6);
    chk("contention last fetch word", bus.if_rdata_o, 16'hA041);
    chk("contention last data word", bus.dm_rdata_o, 16'hA085);

    // Streaming fetch of addresses 0..7
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      bus.if_req_i  = (k < 8);
      bus.if_addr_i = 8'(k < 8 ? k : 0);
      #3;
      if (k < 8 && bus.if_ack_o) acks++;
      if (k >= 3 && k <= 10) begin
        chk("stream rvalid", bus.if_rvalid_o, 1);
        chk("stream rdata", bus.if_rdata_o, 32'h100 + k - 3);
      end else begin
        chk("stream rvalid idle", bus.if_rvalid_o, 0);
      end
      tick();
    end
    chk("stream ack count", acks, 8);

    // Reset with a fetch read in flight
    bus.if_req_i = 1'b1; bus.if_addr_i = 8'h05;
    #3 chk("flight ack c0", bus.if_ack_o, 1);
    tick(); bus.if_req_i = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async rst ram_re", bus.ram_re_o, 0);
       chk("async rst ram_addr", bus.ram_addr_o, 0);
       chk("async rst if_rdata", bus.if_rdata_o, 0);
       chk("async rst starve_cnt", dut.r_starve_cnt, 0);
    tick(); rst = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      #3 chk("flight no if_rvalid", bus.if_rvalid_o, 0);
         chk("flight no dm_rvalid", bus.dm_rvalid_o, 0);
      tick();
    end
    bus.if_req_i = 1'b1; bus.if_addr_i = 8'h06;
    #3 chk("post-rst ack", bus.if_ack_o, 1);
    tick(); bus.if_req_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #3 chk("post-rst if_rvalid", bus.if_rvalid_o, (k == 3));
      if (k == 3) chk("post-rst if_rdata", bus.if_rdata_o, 16'h0106);
      tick();
    end

    // Reset clears a partly built-up starvation count
    bus.if_req_i = 1'b1; bus.if_addr_i = 8'h50;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 8'h90;
    tick(); bus.dm_addr_i = 8'h91;
    tick(); bus.dm_addr_i = 8'h92;
    #2 rst = 1'b1;
    #1 chk("starve_cnt cleared by reset", dut.r_starve_cnt, 0);
    tick(); rst = 1'b0;
    pat4 = '0;
    for (int k = 0; k < 4; k++) begin
      #3 pat4 = {pat4[2:0], bus.dm_ack_o};
      ai = bus.if_ack_o; ad = bus.dm_ack_o;
      tick();
      if (ai) bus.if_addr_i = bus.if_addr_i + 1'b1;
      if (ad) bus.dm_addr_i = bus.dm_addr_i + 1'b1;
    end
    chk("post-rst grants DDDI", pat4, 4'b1110);
    bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/risc16_mem_arb.md
# risc16_mem_arb

Single-port memory arbiter for the RISC-16 core. Shares one synchronous single-port RAM (MEM_ADDR_WIDTH x MEM_DATA_WIDTH) between two requesters:

- the instruction-fetch port (read-only);
- the MEM-stage data port (read/write, driven from `mem_task_t` / `id_res_t` fields).

It issues at most one RAM access per cycle. The data port has priority, bounded by a fetch-starvation counter. Each read response is routed back to the requester that issued it.

## Interface

Parameters:

- `ADDR_W`, default 8: RAM address width. Equal to MEM_ADDR_WIDTH.
- `DATA_W`, default 16: RAM data width. Equal to MEM_DATA_WIDTH.
- `STARVE_LIMIT`, default 3: maximum consecutive data grants while fetch is pending. Legal range is 1 or greater.

Ports. One clock; reset is asynchronous and active-high.

- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `if_req_i` in 1: fetch request. Held with a stable address until acked.
- `if_addr_i` in ADDR_W: fetch address.
- `if_ack_o` out 1: fetch request accepted this cycle.
- `if_rvalid_o` out 1: one-cycle pulse; `if_rdata_o` is valid.
- `if_rdata_o` out DATA_W: fetched word.
- `dm_req_i` in 1: data request. Held with stable address, data and write enable until acked.
- `dm_we_i` in 1: 1 = write, 0 = read.
- `dm_addr_i` in ADDR_W: data address.
- `dm_wdata_i` in DATA_W: write data.
- `dm_ack_o` out 1: data request accepted this cycle.
- `dm_rvalid_o` out 1: one-cycle pulse for data reads only.
- `dm_rdata_o` out DATA_W: read word.
- `ram_re_o` out 1: RAM read strobe (registered).
- `ram_we_o` out 1: RAM write strobe (registered).
- `ram_addr_o` out ADDR_W: RAM address (registered).
- `ram_wdata_o` out DATA_W: RAM write data (registered).
- `ram_rdata_i` in DATA_W: RAM read data, valid the cycle after `ram_re_o`.

## Operation

Grant logic (combinational from the requests and the starvation counter):

- Only `if_req_i` high: grant fetch.
- Only `dm_req_i` high: grant data.
- Both high:
  - grant data if `starve_cnt < STARVE_LIMIT`;
  - otherwise grant fetch.
- Neither high: no grant. RAM strobes are 0 the next cycle.

Acks:

- `if_ack_o` and `dm_ack_o` equal the grant and are mutually exclusive.
- A requester may drop its request, or present a new one, in the cycle after its ack.

Starvation counter (`starve_cnt`), width $clog2(STARVE_LIMIT+1):

- Increments on a data grant while `if_req_i` is high.
- Clears on any fetch grant, or any cycle with `if_req_i` low.
- Saturates at STARVE_LIMIT.

Issue and response:

- At the granting edge, address, write data and strobes are registered onto `ram_*_o`.
- A 2-entry response pipeline is loaded in step with the command:
  - stage 1 holds {valid, port};
  - stage 2 holds the same, aligned with `ram_rdata_i`.
- Writes load no response entry and produce no rvalid.
- When stage 2 is valid, `ram_rdata_i` is registered into the owning port's `rdata_o` and that port's `rvalid_o` pulses.
- `rdata_o` holds its value until that port's next response.

Ordering:

- Accesses execute in grant order.
- A read granted after a write to the same address returns the new data; no bypass logic is needed because the RAM port is single.

Outputs for each register: `ram_*_o` are registered. `if_rvalid_o`, `dm_rvalid_o`, `if_rdata_o` and `dm_rdata_o` are registered.

## Timing

- Request high in cycle N with grant: ack is high in cycle N.
- RAM command visible in cycle N+1.
- RAM data in cycle N+2.
- `rvalid_o` / `rdata_o` in cycle N+3. Read latency is 3 cycles.
- Throughput: one access per cycle sustained. Responses are returned in order, one per cycle at most.
- No combinational path from `ram_rdata_i` to any output, or from any request to `ram_*_o`.

Reset (asynchronous, takes effect immediately):

- All outputs go to 0: acks, rvalids, rdata, `ram_re_o`, `ram_we_o`, `ram_addr_o`, `ram_wdata_o`.
- `starve_cnt` is 0 and both response stages are invalid.
- Reset mid-operation: in-flight reads are discarded and produce no rvalid after reset.
- A write registered before reset may or may not have reached the RAM; requesters must reissue it.
- The first grant is possible in the first cycle after `rst_i` is deasserted.

## Test plan

- Reset: assert `rst_i` asynchronously mid-cycle → all outputs 0 immediately; no ack until the cycle after deassert.
- Single fetch: RAM[0x10] = 0xBEEF, `if_req_i` held one cycle at address 0x10 → `if_ack_o` in cycle 0; `ram_re_o` = 1 and `ram_addr_o` = 0x10 in cycle 1; `if_rvalid_o` = 1 with `if_rdata_o` = 0xBEEF in cycle 3 only; `dm_rvalid_o` stays 0.
- Write then read: data write of 0x1234 to 0x20, then data read of 0x20 in the next cycle → `ram_we_o` in cycle 1, `ram_re_o` in cycle 2; `dm_rvalid_o` in cycle 4 with 0x1234; exactly one rvalid pulse.
- Contention: `STARVE_LIMIT` = 3, both ports requesting continuously → grant sequence D, D, D, I, D, D, D, I; each rvalid goes to the correct port with the correct data.
- Streaming fetch: RAM[i] = 0x100 + i, fetch addresses 0..7 on consecutive cycles → 8 consecutive acks; `if_rvalid_o` high for 8 consecutive cycles with data 0x100..0x107 in order.
- Reset with reads in flight: fetch read acked in cycle 0, `rst_i` pulsed in cycle 1 → no rvalid in cycles 1–5; `starve_cnt` = 0; a new read after reset completes normally with latency 3.
